sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/lenet_mem_pkg.sv | 23 ++
 rtl/rr_lock_arb2.sv | 84 ++++++++
 rtl/sram_port_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/lenet_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_mem_pkg
// Description : Shared constants and types for the SRAM port arbiter.
//               NUM_REQ     - number of requesters per SRAM port
//               REQ_LOADER  - requester index of the loader
//               REQ_PE      - requester index of the processing element
//               arb_state_t - per-port arbitration state (RR / LOCKED)
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_mem_pkg;

  localparam int NUM_REQ    = 2;
  localparam int REQ_LOADER = 0;
  localparam int REQ_PE     = 1;

  typedef enum logic [0:0] {
    RR     = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage : lenet_mem_pkg
`default_nettype wire

// File: rtl/rr_lock_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arb2
// Description : Two-way round-robin arbiter with burst lock.
//               RR     : grant the favoured requester, else the other one.
//               LOCKED : only the lock owner may be granted.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   req_i    in   request per requester
//   lock_i   in   burst-lock per requester, sampled with req_i
//   gnt_o    out  one-hot combinational grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arb2
  import lenet_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  arb_state_t         state_q, state_d;
  logic               owner_q, owner_d;
  logic               ptr_q,   ptr_d;    // requester currently favoured
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RR;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    gnt     = '0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    case (state_q)
      RR: begin
        if (req_i[ptr_q])       gnt[ptr_q]  = 1'b1;
        else if (req_i[~ptr_q]) gnt[~ptr_q] = 1'b1;
      end
      LOCKED: begin
        gnt[owner_q] = req_i[owner_q];
      end
      default: gnt = '0;
    endcase

    gnt_idx = gnt[1];

    // Every granted beat hands priority to the other requester, so when a
    // lock ends (either way) the non-owner is already favoured.
    if (|gnt) ptr_d = ~gnt_idx;

    case (state_q)
      RR: begin
        if ((|gnt) && lock_i[gnt_idx]) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end
      LOCKED: begin
        // Last beat (lock low) or abandoned burst (request low) both release.
        if (!req_i[owner_q] || !lock_i[owner_q]) state_d = RR;
      end
      default: state_d = RR;
    endcase
  end

  // Grants are combinational, so they must be forced low during reset too.
  assign gnt_o = rst_n ? gnt : '0;

endmodule : rr_lock_arb2
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Arbitrates a loader and a PE onto one SRAM with independent
//               write and read ports, each with round-robin plus burst lock.
//   clk, rst_n                      clock, async active-low reset
//   wr_req/wr_lock/wr_addr_in/wr_data_in, wr_gnt   write port requesters
//   rd_req/rd_lock/rd_addr_in, rd_gnt              read port requesters
//   rd_rvalid, rd_rdata             read return (one cycle after grant)
//   sram_*                          SRAM controls, address, data
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
  import lenet_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ-1:0]            wr_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_in,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ-1:0]            rd_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_in,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [NUM_REQ-1:0]            rd_rvalid,
  output logic [DATA_WIDTH-1:0]         rd_rdata,
  output logic                          sram_csen,
  output logic                          sram_wr_en,
  output logic                          sram_rd_en,
  output logic [ADDR_WIDTH-1:0]         sram_wr_addr,
  output logic [DATA_WIDTH-1:0]         sram_wr_data,
  output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         sram_rd_data
);

  logic [NUM_REQ-1:0] rvalid_q;

  rr_lock_arb2 u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (wr_req),
    .lock_i (wr_lock),
    .gnt_o  (wr_gnt)
  );

  rr_lock_arb2 u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (rd_req),
    .lock_i (rd_lock),
    .gnt_o  (rd_gnt)
  );

  assign sram_wr_en = |wr_gnt;
  assign sram_rd_en = |rd_gnt;
  assign sram_csen  = sram_wr_en | sram_rd_en;

  // Address/data come from the granted slice and idle at zero.
  always_comb begin
    sram_wr_addr = '0;
    sram_wr_data = '0;
    sram_rd_addr = '0;
    if (wr_gnt[REQ_PE]) begin
      sram_wr_addr = wr_addr_in[REQ_PE*ADDR_WIDTH +: ADDR_WIDTH];
      sram_wr_data = wr_data_in[REQ_PE*DATA_WIDTH +: DATA_WIDTH];
    end else if (wr_gnt[REQ_LOADER]) begin
      sram_wr_addr = wr_addr_in[REQ_LOADER*ADDR_WIDTH +: ADDR_WIDTH];
      sram_wr_data = wr_data_in[REQ_LOADER*DATA_WIDTH +: DATA_WIDTH];
    end
    if (rd_gnt[REQ_PE]) begin
      sram_rd_addr = rd_addr_in[REQ_PE*ADDR_WIDTH +: ADDR_WIDTH];
    end else if (rd_gnt[REQ_LOADER]) begin
      sram_rd_addr = rd_addr_in[REQ_LOADER*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // rvalid tracks the grant of the previous cycle, matching SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= '0;
    else        rvalid_q <= rd_gnt;
  end

  assign rd_rvalid = rvalid_q;
  assign rd_rdata  = sram_rd_data;

endmodule : sram_port_arbiter
`default_nettype wire
